// File: rtl/uart_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_feeder                                               |
// | Description : Byte FIFO and launch sequencer in front of a UART            |
// |               transmitter. Buffers fabric writes (up to one per clock) and |
// |               hands them one at a time to the transmitter, waiting for its |
// |               done pulse plus GAP_CLKS idle clocks between launches.       |
// | Ports       : i_Clock, i_Rst_L (async, active-low)                         |
// |               i_Wr_DV/i_Wr_Byte  - fabric write strobe and data            |
// |               i_Clr_Ovf          - synchronous clear of o_Overflow         |
// |               i_TX_Active/Done   - status from the UART transmitter        |
// |               o_TX_DV/o_TX_Byte  - launch pulse and byte to transmitter    |
// |               o_Full/o_Empty/o_Count - FIFO occupancy                      |
// |               o_Overflow         - sticky dropped-write flag               |
// |               o_Busy             - FIFO non-empty or sequencer not idle    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_tx_feeder #(
  parameter int DEPTH    = 16,
  parameter int GAP_CLKS = 0
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_L,
  input  logic                   i_Wr_DV,
  input  logic [7:0]             i_Wr_Byte,
  input  logic                   i_Clr_Ovf,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Count,
  output logic                   o_Overflow,
  output logic                   o_Busy
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS + 1) : 1;

  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CLKS);
  localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  state_t               r_state;
  logic [7:0]           r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_GAP_W-1:0]   r_gap_cnt;
  logic                 r_tx_dv;
  logic [7:0]           r_tx_byte;
  logic                 r_overflow;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_drop;
  logic w_launch;

  // Full/empty come from the registered count, so a pop in the same edge
  // never makes room for a write that arrives while full.
  assign w_full   = (r_count == c_CNT_FULL);
  assign w_empty  = (r_count == c_CNT_ZERO);
  assign w_wr_en  = i_Wr_DV && !w_full;
  assign w_drop   = i_Wr_DV && w_full;
  assign w_launch = (r_state == ST_IDLE) && !w_empty && !i_TX_Active;

  // Storage array carries no reset; validity is tracked by the count.
  always_ff @(posedge i_Clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_launch) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_wr_en, w_launch})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_Clr_Ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      r_tx_dv <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_tx_dv   <= 1'b1;
            r_tx_byte <= r_mem[r_rd_ptr];
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_TX_Done) begin
            r_gap_cnt <= c_GAP_LOAD;
            r_state   <= (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          // Counter was loaded with GAP_CLKS; leaving at 1 yields exactly
          // GAP_CLKS clocks spent in this state.
          if (r_gap_cnt == c_GAP_ONE) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_TX_DV    = r_tx_dv;
  assign o_TX_Byte  = r_tx_byte;
  assign o_Full     = w_full;
  assign o_Empty    = w_empty;
  assign o_Count    = r_count;
  assign o_Overflow = r_overflow;
  assign o_Busy     = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_feeder                                            |
// | Description : Self-checking bench for uart_tx_feeder. Two instances        |
// |               (GAP_CLKS=0 and GAP_CLKS=5); the selected one is driven by a |
// |               behavioural transmitter and compared every cycle against a   |
// |               queue-based reference of the feeder's expected behaviour.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wr_dv;
  logic [7:0] wr_byte;
  logic       clr_ovf;
  logic       tx_active;
  logic       tx_done;

  logic          dv0, full0, empty0, ovf0, busy0;
  logic [7:0]    byte0;
  logic [CW-1:0] cnt0;
  logic          dv5, full5, empty5, ovf5, busy5;
  logic [7:0]    byte5;
  logic [CW-1:0] cnt5;

  uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CLKS(0)) u_dut_g0 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
    .i_Clr_Ovf(clr_ovf), .i_TX_Active(tx_active), .i_TX_Done(tx_done),
    .o_TX_DV(dv0), .o_TX_Byte(byte0), .o_Full(full0), .o_Empty(empty0),
    .o_Count(cnt0), .o_Overflow(ovf0), .o_Busy(busy0)
  );

  uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CLKS(5)) u_dut_g5 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
    .i_Clr_Ovf(clr_ovf), .i_TX_Active(tx_active), .i_TX_Done(tx_done),
    .o_TX_DV(dv5), .o_TX_Byte(byte5), .o_Full(full5), .o_Empty(empty5),
    .o_Count(cnt5), .o_Overflow(ovf5), .o_Busy(busy5)
  );

  bit gap_sel;
  int gap_cur;

  logic          s_dv, s_full, s_empty, s_ovf, s_busy;
  logic [7:0]    s_byte;
  logic [CW-1:0] s_cnt;
  assign s_dv    = gap_sel ? dv5    : dv0;
  assign s_byte  = gap_sel ? byte5  : byte0;
  assign s_full  = gap_sel ? full5  : full0;
  assign s_empty = gap_sel ? empty5 : empty0;
  assign s_cnt   = gap_sel ? cnt5   : cnt0;
  assign s_ovf   = gap_sel ? ovf5   : ovf0;
  assign s_busy  = gap_sel ? busy5  : busy0;

  // Reference: queue of buffered bytes plus edge-number bookkeeping.
  logic [7:0] mq[$];
  int         edge_n;
  int         idle_edge;   // sequencer is idle after this edge onward
  int         wait_from;   // first edge at which a done pulse is accepted
  bit         in_flight;
  bit         m_ovf;
  bit         m_dv;
  logic [7:0] m_byte;
  bit         m_busy;

  // Behavioural transmitter
  int tx_cnt;
  bit hold_active;
  bit spur_en;
  int frame_lo, frame_hi;

  int total, bad;
  int dv_seen;
  int last_done_edge;
  int gap_meas;
  bit saw_ff;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the
  // reference across the next rising edge, then compare at the next fall.
  task automatic step(input bit wr, input logic [7:0] b, input bit clr);
    bit act, done, full_pre, launch;
    int n;
    act  = hold_active;
    done = 1'b0;
    if (tx_cnt > 1) begin
      act = 1'b1;
      tx_cnt--;
    end else if (tx_cnt == 1) begin
      done   = 1'b1;
      tx_cnt = 0;
    end else if (spur_en && $urandom_range(0, 15) == 0) begin
      done = 1'b1;
    end
    if (s_dv) tx_cnt = $urandom_range(frame_lo, frame_hi);

    wr_dv = wr; wr_byte = b; clr_ovf = clr; tx_active = act; tx_done = done;

    n        = edge_n + 1;
    full_pre = (mq.size() == DEPTH);
    launch   = (mq.size() > 0) && !act && !in_flight && (n > idle_edge);
    if (done) last_done_edge = n;
    if (in_flight && done && n >= wait_from) begin
      in_flight = 1'b0;
      idle_edge = n + gap_cur;
    end
    m_dv = launch;
    if (launch) begin
      m_byte    = mq.pop_front();
      in_flight = 1'b1;
      wait_from = n + 2;
    end
    if (wr) begin
      if (full_pre) m_ovf = 1'b1;
      else          mq.push_back(b);
    end
    if (clr && !(wr && full_pre)) m_ovf = 1'b0;
    m_busy = (mq.size() > 0) || in_flight || (n < idle_edge);

    @(posedge clk);
    edge_n = n;
    @(negedge clk);
    chk("dv",    32'(s_dv),    32'(m_dv));
    chk("byte",  32'(s_byte),  32'(m_byte));
    chk("count", 32'(s_cnt),   32'(mq.size()));
    chk("full",  32'(s_full),  32'(mq.size() == DEPTH));
    chk("empty", 32'(s_empty), 32'(mq.size() == 0));
    chk("ovf",   32'(s_ovf),   32'(m_ovf));
    chk("busy",  32'(s_busy),  32'(m_busy));
    if (s_dv) begin
      dv_seen++;
      gap_meas = n - last_done_edge + 1;
      if (s_byte == 8'hFF) saw_ff = 1'b1;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; wr_dv = 1'b0; clr_ovf = 1'b0; tx_active = 1'b0; tx_done = 1'b0;
    #1;
    mq.delete();
    in_flight = 1'b0; m_ovf = 1'b0; m_dv = 1'b0; m_byte = 8'h00;
    idle_edge = -1; wait_from = 0; tx_cnt = 0; last_done_edge = -100;
    chk("rst_dv",    32'(s_dv),    32'd0);
    chk("rst_byte",  32'(s_byte),  32'h00);
    chk("rst_count", 32'(s_cnt),   32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full",  32'(s_full),  32'd0);
    chk("rst_ovf",   32'(s_ovf),   32'd0);
    chk("rst_busy",  32'(s_busy),  32'd0);
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while ((mq.size() > 0 || in_flight || edge_n < idle_edge || tx_cnt > 0) && k < lim) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    chk("drain_timeout", 32'(k < lim), 32'd1);
  endtask

  task automatic rand_run(input int cycles, input int pct);
    for (int i = 0; i < cycles; i++) begin
      step(($urandom_range(0, 99) < pct), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 24) == 0));
    end
  endtask

  initial begin
    total = 0; bad = 0; edge_n = 0; gap_sel = 1'b0; gap_cur = 0;
    hold_active = 1'b0; spur_en = 1'b0; frame_lo = 10; frame_hi = 10;
    dv_seen = 0; gap_meas = 0; saw_ff = 1'b0; wr_byte = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset(3);

    // Single byte
    dv_seen = 0;
    step(1'b1, 8'hA5, 1'b0);
    drain(100);
    chk("single_dv_cnt", 32'(dv_seen), 32'd1);
    chk("single_busy",   32'(s_busy),  32'd0);

    // Burst of 16 with a 4-clocks-per-bit 10-bit frame
    dv_seen = 0; frame_lo = 40; frame_hi = 40;
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    drain(2000);
    chk("burst_dv_cnt", 32'(dv_seen), 32'd16);

    // Overflow with the transmitter held busy
    frame_lo = 6; frame_hi = 6; saw_ff = 1'b0; hold_active = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 254)), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_full",  32'(s_full), 32'd1);
    chk("ovf_flag",  32'(s_ovf),  32'd1);
    chk("ovf_count", 32'(s_cnt),  32'd16);
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_clr", 32'(s_ovf), 32'd0);
    step(1'b1, 8'hFF, 1'b1);
    chk("ovf_drop_wins", 32'(s_ovf), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    hold_active = 1'b0;
    drain(500);
    chk("ff_never_sent", 32'(saw_ff), 32'd0);

    // Write on the launch edge with three queued
    hold_active = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    hold_active = 1'b0;
    step(1'b1, 8'h33, 1'b0);
    chk("simul_dv",    32'(s_dv),  32'd1);
    chk("simul_count", 32'(s_cnt), 32'd3);
    drain(500);

    // Randomized traffic with spurious done pulses
    spur_en = 1'b1; frame_lo = 2; frame_hi = 12;
    rand_run(300, 30);
    rand_run(300, 90);
    spur_en = 1'b0;
    drain(2000);

    // Reset while waiting for done with 4 queued
    frame_lo = 30; frame_hi = 30;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("midop_count", 32'(s_cnt),  32'd4);
    chk("midop_busy",  32'(s_busy), 32'd1);
    do_reset(2);
    dv_seen = 0;
    repeat (20) step(1'b0, 8'h00, 1'b0);
    chk("no_dv_after_rst", 32'(dv_seen), 32'd0);

    // Gap instance: done-to-next-launch spacing
    gap_sel = 1'b1; gap_cur = 5; frame_lo = 6; frame_hi = 6;
    do_reset(2);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    drain(200);
    chk("gap_spacing", 32'(gap_meas), 32'd7);
    spur_en = 1'b1; frame_lo = 2; frame_hi = 10;
    rand_run(300, 50);
    spur_en = 1'b0;
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
